// File: rtl/robo_render_if.sv
// Bundle of the robo_render scan, map-write, position-update and pixel signals.
// The master side drives scan position, map writes and robot updates; the
// slave side (the renderer) returns the handshake, error pulse, colour and
// the free-running frame counter.
interface robo_render_if;
    logic [9:0]  linha;
    logic [9:0]  coluna;
    logic        map_we;
    logic [8:0]  map_addr;
    logic [1:0]  map_data;
    logic        pos_valid;
    logic [4:0]  robo_x;
    logic [3:0]  robo_y;
    logic [1:0]  robo_dir;
    logic        pos_ready;
    logic        pos_err;
    logic [23:0] rgb;
    logic [5:0]  frame_cnt;

    modport master (
        output linha, coluna, map_we, map_addr, map_data,
               pos_valid, robo_x, robo_y, robo_dir,
        input  pos_ready, pos_err, rgb, frame_cnt
    );

    modport slave (
        input  linha, coluna, map_we, map_addr, map_data,
               pos_valid, robo_x, robo_y, robo_dir,
        output pos_ready, pos_err, rgb, frame_cnt
    );
endinterface

// File: rtl/robo_render.sv
// Tile-map renderer for a 20x15 grid of 32x32 px cells with one robot sprite.
// Two-stage pipeline: stage 1 latches scan coordinates and the map cell,
// stage 2 resolves colour priority and registers RGB.
// Robot position updates are double-buffered and applied only at the first
// cycle of Linha==480, so the visible frame never tears.
// Optional build macro: ROBO_BLINK_EN -- robot drawn only while frame
// counter bit 4 is 0 (16 frames on, 16 off).
module robo_render (
    input  logic      clk,
    input  logic      rst_n,
    robo_render_if.slave bus
);
    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [23:0] COL_BLACK    = 24'h000000;
    localparam logic [23:0] COL_MARKER   = 24'hFF0000;
    localparam logic [23:0] COL_BODY     = 24'hFFD700;
    localparam logic [23:0] COL_GRID     = 24'h404040;
    localparam logic [23:0] COL_EMPTY    = 24'h101010;
    localparam logic [23:0] COL_BARRIER  = 24'h8B4513;
    localparam logic [23:0] COL_DEBRIS   = 24'h00A000;
    localparam logic [23:0] COL_RESERVED = 24'hFF00FF;

    // ------------------------------------------------------------------
    // Map storage
    // ------------------------------------------------------------------
    logic [1:0] map_mem [300];
    logic       active_in;
    logic [8:0] rd_addr;

    assign active_in = (bus.linha < 10'd480) && (bus.coluna < 10'd640);
    // Outside the active area the cell indices can exceed the map, so the
    // read address is parked at 0 there.
    assign rd_addr   = active_in ? (9'(bus.linha[8:5]) * 9'd20 + 9'(bus.coluna[9:5]))
                                 : 9'd0;

    // Map write port; out-of-range addresses are dropped.
    // NOTE: the map must power up as all-empty cells, so this register array
    // is deliberately in the async reset; it stays small enough to be flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 300; i++) map_mem[i] <= 2'd0;
        end else if (bus.map_we && (bus.map_addr < 9'd300)) begin
            map_mem[bus.map_addr] <= bus.map_data;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: coordinates, active flag and map cell
    // ------------------------------------------------------------------
    logic       s1_active;
    logic [4:0] s1_cx;
    logic [3:0] s1_cy;
    logic [4:0] s1_lx;
    logic [4:0] s1_ly;
    logic [1:0] s1_cell;

    // Latch the scan position and the map cell it points at (read-before-write).
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes a same-cycle write return
    // the old map data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_active <= 1'b0;
            s1_cx     <= 5'd0;
            s1_cy     <= 4'd0;
            s1_lx     <= 5'd0;
            s1_ly     <= 5'd0;
            s1_cell   <= 2'd0;
        end else begin
            s1_active <= active_in;
            s1_cx     <= bus.coluna[9:5];
            s1_cy     <= bus.linha[8:5];
            s1_lx     <= bus.coluna[4:0];
            s1_ly     <= bus.linha[4:0];
            s1_cell   <= active_in ? map_mem[rd_addr] : 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Frame boundary and frame counter
    // ------------------------------------------------------------------
    logic       at_480;
    logic       at_480_q;
    logic       boundary;
    logic [5:0] frame_cnt;

    assign at_480   = (bus.linha == 10'd480);
    assign boundary = at_480 && !at_480_q;

    // Edge-detect the start of vertical blanking and count frames (wraps at 64).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_480_q  <= 1'b0;
            frame_cnt <= 6'd0;
        end else begin
            at_480_q <= at_480;
            if (boundary) frame_cnt <= frame_cnt + 6'd1;
        end
    end

    // ------------------------------------------------------------------
    // Position handshake: pending register and displayed position
    // ------------------------------------------------------------------
    logic       pend_full;
    logic [4:0] pend_x;
    logic [3:0] pend_y;
    logic [1:0] pend_dir;
    logic [4:0] disp_x;
    logic [3:0] disp_y;
    logic [1:0] disp_dir;
    logic       err_q;
    logic       take;
    logic       in_range;

    assign take     = bus.pos_valid && !pend_full;
    assign in_range = (bus.robo_x < 5'd20) && (bus.robo_y < 4'd15);

    // Accept updates while empty; promote pending to displayed at the boundary.
    // A boundary with an empty pending slot can still accept a new update,
    // which then waits for the following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
            pend_x    <= 5'd0;
            pend_y    <= 4'd0;
            pend_dir  <= DIR_N;
            disp_x    <= 5'd0;
            disp_y    <= 4'd0;
            disp_dir  <= DIR_N;
            err_q     <= 1'b0;
        end else begin
            err_q <= take && !in_range;
            if (boundary && pend_full) begin
                disp_x    <= pend_x;
                disp_y    <= pend_y;
                disp_dir  <= pend_dir;
                pend_full <= 1'b0;
            end else if (take && in_range) begin
                pend_x    <= bus.robo_x;
                pend_y    <= bus.robo_y;
                pend_dir  <= bus.robo_dir;
                pend_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour resolution
    // ------------------------------------------------------------------
    logic        robot_show;
    logic        in_robot_cell;
    logic        in_body;
    logic        on_marker;
    logic [23:0] rgb_next;
    logic [23:0] rgb_q;

`ifdef ROBO_BLINK_EN
    assign robot_show = ~frame_cnt[4];
`else
    assign robot_show = 1'b1;
`endif

    assign in_robot_cell = robot_show && (s1_cx == disp_x) && (s1_cy == disp_y);
    assign in_body       = (s1_lx >= 5'd8) && (s1_lx <= 5'd23) &&
                           (s1_ly >= 5'd8) && (s1_ly <= 5'd23);

    // Direction marker: a 4x8 strip on the facing edge of the body.
    // NOTE: the default assignment before the case keeps this purely
    // combinational; without it a missed branch would infer a latch.
    always_comb begin
        on_marker = 1'b0;
        case (disp_dir)
            DIR_N: on_marker = (s1_ly >= 5'd8)  && (s1_ly <= 5'd11) &&
                               (s1_lx >= 5'd12) && (s1_lx <= 5'd19);
            DIR_E: on_marker = (s1_lx >= 5'd20) && (s1_lx <= 5'd23) &&
                               (s1_ly >= 5'd12) && (s1_ly <= 5'd19);
            DIR_S: on_marker = (s1_ly >= 5'd20) && (s1_ly <= 5'd23) &&
                               (s1_lx >= 5'd12) && (s1_lx <= 5'd19);
            DIR_W: on_marker = (s1_lx >= 5'd8)  && (s1_lx <= 5'd11) &&
                               (s1_ly >= 5'd12) && (s1_ly <= 5'd19);
            default: on_marker = 1'b0;
        endcase
    end

    // Colour priority: blank, marker, body, grid line, cell content.
    always_comb begin
        rgb_next = COL_BLACK;
        if (!s1_active) begin
            rgb_next = COL_BLACK;
        end else if (in_robot_cell && on_marker) begin
            rgb_next = COL_MARKER;
        end else if (in_robot_cell && in_body) begin
            rgb_next = COL_BODY;
        end else if ((s1_lx == 5'd0) || (s1_ly == 5'd0)) begin
            rgb_next = COL_GRID;
        end else begin
            case (s1_cell)
                2'd0:    rgb_next = COL_EMPTY;
                2'd1:    rgb_next = COL_BARRIER;
                2'd2:    rgb_next = COL_DEBRIS;
                default: rgb_next = COL_RESERVED;
            endcase
        end
    end

    // Register the pixel colour towards the VGA interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb_q <= COL_BLACK;
        else        rgb_q <= rgb_next;
    end

    assign bus.rgb       = rgb_q;
    assign bus.pos_ready = !pend_full;
    assign bus.pos_err   = err_q;
    assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_robo_render.sv
// Scoreboard bench for robo_render: a driver issues one scan position per
// cycle, a reference model computes the expected colour and handshake from
// the cell/pixel rules and queues them with their due cycle, and a monitor on
// the falling edge pops and compares. Works with or without ROBO_BLINK_EN.
module tb_robo_render;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    robo_render_if bus ();
    robo_render dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int          due;
        logic [23:0] rgb;
        string       tag;
    } pix_t;

    typedef struct {
        int due;
        bit rdy;
        bit err;
        int frame;
    } hs_t;

    pix_t pix_q[$];
    hs_t  hs_q[$];

    // Reference model state
    int m_map [300];
    int m_dx, m_dy, m_dd;
    int m_px, m_py, m_pd;
    bit m_full;
    int m_frame;
    bit m_prev480;

    // Optional literal expectation attached to the next tick
    bit          lit_on = 1'b0;
    logic [23:0] lit_val;
    string       lit_tag;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] ref_color(input int l, input int c);
        int cx, cy, lx, ly;
        bit show, robot, body, marker;
        if (l >= 480 || c >= 640) return 24'h000000;
        cx = c / 32; cy = l / 32; lx = c % 32; ly = l % 32;
`ifdef ROBO_BLINK_EN
        show = (m_frame % 32) < 16;
`else
        show = 1'b1;
`endif
        robot = show && (cx == m_dx) && (cy == m_dy);
        body  = (lx >= 8 && lx <= 23 && ly >= 8 && ly <= 23);
        case (m_dd)
            0: marker = (ly >= 8  && ly <= 11 && lx >= 12 && lx <= 19);
            1: marker = (lx >= 20 && lx <= 23 && ly >= 12 && ly <= 19);
            2: marker = (ly >= 20 && ly <= 23 && lx >= 12 && lx <= 19);
            default: marker = (lx >= 8 && lx <= 11 && ly >= 12 && ly <= 19);
        endcase
        if (robot && marker) return 24'hFF0000;
        if (robot && body)   return 24'hFFD700;
        if (lx == 0 || ly == 0) return 24'h404040;
        case (m_map[cy * 20 + cx])
            0: return 24'h101010;
            1: return 24'h8B4513;
            2: return 24'h00A000;
            default: return 24'hFF00FF;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 300; i++) m_map[i] = 0;
        m_dx = 0; m_dy = 0; m_dd = 0;
        m_px = 0; m_py = 0; m_pd = 0;
        m_full = 1'b0; m_frame = 0; m_prev480 = 1'b0;
    endtask

    // One scan cycle: drive inputs, queue expectations, advance the model.
    task automatic tick(input int l, input int c,
                        input bit pv = 1'b0, input int x = 0, input int y = 0, input int d = 0,
                        input bit we = 1'b0, input int addr = 0, input int data = 0);
        bit boundary, err;
        @(posedge clk); #1;
        bus.linha     = 10'(l);
        bus.coluna    = 10'(c);
        bus.pos_valid = pv;
        bus.robo_x    = 5'(x);
        bus.robo_y    = 4'(y);
        bus.robo_dir  = 2'(d);
        bus.map_we    = we;
        bus.map_addr  = 9'(addr);
        bus.map_data  = 2'(data);
        pix_q.push_back('{cyc + 2, ref_color(l, c), "rgb_model"});
        if (lit_on) begin
            pix_q.push_back('{cyc + 2, lit_val, lit_tag});
            lit_on = 1'b0;
        end
        boundary  = (l == 480) && !m_prev480;
        m_prev480 = (l == 480);
        err = 1'b0;
        if (boundary) m_frame = (m_frame + 1) % 64;
        if (boundary && m_full) begin
            m_dx = m_px; m_dy = m_py; m_dd = m_pd; m_full = 1'b0;
        end else if (pv && !m_full) begin
            if (x < 20 && y < 15) begin
                m_px = x; m_py = y; m_pd = d; m_full = 1'b1;
            end else begin
                err = 1'b1;
            end
        end
        if (we && addr < 300) m_map[addr] = data;
        hs_q.push_back('{cyc + 1, !m_full, err, m_frame});
    endtask

    task automatic tick_lit(input string tag, input logic [23:0] v, input int l, input int c);
        lit_on = 1'b1; lit_val = v; lit_tag = tag;
        tick(l, c);
    endtask

    // Assert reset mid-stream, check reset outputs, then release.
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.pos_valid = 1'b0;
        bus.map_we    = 1'b0;
        pix_q.delete();
        hs_q.delete();
        model_reset();
        #5;
        check("reset_rgb", bus.rgb, 24'h0);
        check("reset_pos_ready", 24'(bus.pos_ready), 24'd1);
        check("reset_pos_err", 24'(bus.pos_err), 24'd0);
        check("reset_frame_cnt", 24'(bus.frame_cnt), 24'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every queued expectation on its due cycle.
    always @(negedge clk) begin
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            pix_t e;
            e = pix_q.pop_front();
            if (e.due < cyc) begin
                mismatched++;
                $display("FAIL stale_%s: due %0d seen %0d", e.tag, e.due, cyc);
            end else begin
                check(e.tag, bus.rgb, e.rgb);
            end
        end
        while (hs_q.size() > 0 && hs_q[0].due <= cyc) begin
            hs_t h;
            h = hs_q.pop_front();
            check("pos_ready", 24'(bus.pos_ready), 24'(h.rdy));
            check("pos_err", 24'(bus.pos_err), 24'(h.err));
            check("frame_cnt", 24'(bus.frame_cnt), 24'(h.frame));
        end
    end

    initial begin
        bus.linha = '0; bus.coluna = '0; bus.map_we = 1'b0; bus.map_addr = '0;
        bus.map_data = '0; bus.pos_valid = 1'b0; bus.robo_x = '0; bus.robo_y = '0;
        bus.robo_dir = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Grid line and blanking
        tick_lit("grid_l0_c100", 24'h404040, 0, 100);
        tick_lit("blank_c700", 24'h000000, 0, 700);

        // Map write, ignored out-of-range write, read-old-on-same-cycle
        tick(0, 0, 0, 0, 0, 0, 1'b1, 21, 1);
        tick_lit("barrier_40_40", 24'h8B4513, 40, 40);
        tick(0, 0, 0, 0, 0, 0, 1'b1, 300, 3);
        lit_on = 1'b1; lit_val = 24'h8B4513; lit_tag = "same_cycle_old";
        tick(40, 40, 0, 0, 0, 0, 1'b1, 21, 2);
        tick_lit("debris_40_40", 24'h00A000, 40, 40);

        // Position update deferred until the frame boundary
        tick(100, 5, 1'b1, 3, 2, 1);
        tick_lit("old_body_16_16", 24'hFFD700, 16, 16);
        tick_lit("old_marker_10_16", 24'hFF0000, 10, 16);
        tick(479, 639);
        tick(480, 0);
        tick(480, 1);
        tick_lit("new_marker_E", 24'hFF0000, 80, 116);
        tick_lit("new_body", 24'hFFD700, 72, 104);
        tick_lit("old_cell_cleared", 24'h101010, 16, 16);

        // Out-of-range updates
        tick(10, 10, 1'b1, 25, 2, 0);
        tick(10, 10);
        tick(10, 10, 1'b1, 4, 15, 0);
        tick(10, 10);

        // Update captured on the boundary cycle waits one more frame
        tick(480, 0, 1'b1, 5, 5, 2);
        tick_lit("still_old_pos", 24'hFF0000, 80, 116);
        tick(0, 0);
        tick(480, 0);
        tick_lit("deferred_marker_S", 24'hFF0000, 180, 172);

        // Randomized frames with a mid-line reset after frame 5
        for (int f = 0; f < 45; f++) begin
            for (int k = 0; k < 40; k++) begin
                int l, c;
                if (($urandom % 4) == 0) begin
                    l = m_dy * 32 + int'($urandom % 32);
                    c = m_dx * 32 + int'($urandom % 32);
                end else begin
                    l = int'($urandom_range(0, 479));
                    c = int'($urandom_range(0, 700));
                end
                tick(l, c,
                     ($urandom % 6) == 0, int'($urandom_range(0, 22)),
                     int'($urandom_range(0, 16)), int'($urandom % 4),
                     ($urandom % 3) == 0, int'($urandom_range(0, 319)), int'($urandom % 4));
                if (f == 5 && k == 20) begin
                    do_reset();
                    tick_lit("post_reset_body", 24'hFFD700, 16, 16);
                end
            end
            tick(480, int'($urandom_range(0, 799)), ($urandom % 2) == 0,
                 int'($urandom_range(0, 21)), int'($urandom_range(0, 15)), int'($urandom % 4));
            tick(480 + int'($urandom_range(0, 40)), 0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        if (pix_q.size() != 0 || hs_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d pixel and %0d handshake expectations left", pix_q.size(), hs_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
